// File: rtl/addern_serial.sv
// addern_serial: N-bit bit-serial adder with operand registers, a start/done
// handshake, optional accumulate write-back and seven-segment result display.
// Optional macro ADDERN_SUB_EN enables subtract mode (A + ~B + 1) via 'sub'.
module addern_serial #(
    parameter int N          = 8,
    parameter int ACCUMULATE = 0,
    localparam int NDIG      = (N + 3) / 4
) (
    input  logic              CLOCK_50,
    input  logic              Resetn,
    input  logic [N-1:0]      data_in,
    input  logic              load_a,
    input  logic              load_b,
    input  logic              start,
    input  logic              sub,
    output logic              busy,
    output logic              done,
    output logic [N-1:0]      sum,
    output logic              cout,
    output logic              overflow,
    output logic [7*NDIG-1:0] hex_out
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);
    localparam int PW = 4 * NDIG;

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t        state;
    logic [N-1:0]  reg_a, reg_b;
    logic [N-1:0]  work_a, work_b, shift_s;
    logic [CW-1:0] cnt;
    logic          carry, carry_msb, sub_q;
    logic          load_a_prev, load_b_prev, start_prev;
    logic          load_a_rise, load_b_rise, start_rise;
    logic          sub_eff;
    logic          b_bit, s_bit, c_next;
    logic [PW-1:0] sum_pad;

`ifdef ADDERN_SUB_EN
    assign sub_eff = sub;
`else
    // Port kept for pin compatibility; subtraction is masked off.
    assign sub_eff = sub & 1'b0;
`endif

    assign load_a_rise = load_a & ~load_a_prev;
    assign load_b_rise = load_b & ~load_b_prev;
    assign start_rise  = start & ~start_prev;

    assign b_bit  = work_b[0] ^ sub_q;
    assign s_bit  = work_a[0] ^ b_bit ^ carry;
    assign c_next = (work_a[0] & b_bit) | (work_a[0] & carry) | (b_bit & carry);

    // Single-register history for rising-edge detection of the control levels
    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            load_a_prev <= 1'b0;
            load_b_prev <= 1'b0;
            start_prev  <= 1'b0;
        end else begin
            load_a_prev <= load_a;
            load_b_prev <= load_b;
            start_prev  <= start;
        end
    end

    // Control FSM, operand registers and serial datapath with registered outputs
    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            state     <= IDLE;
            reg_a     <= '0;
            reg_b     <= '0;
            work_a    <= '0;
            work_b    <= '0;
            shift_s   <= '0;
            cnt       <= '0;
            carry     <= 1'b0;
            carry_msb <= 1'b0;
            sub_q     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_a_rise) reg_a <= data_in;
                    if (load_b_rise) reg_b <= data_in;
                    if (start_rise && !load_a_rise && !load_b_rise) begin
                        state  <= RUN;
                        cnt    <= '0;
                        carry  <= sub_eff;
                        sub_q  <= sub_eff;
                        work_a <= reg_a;
                        work_b <= reg_b;
                    end
                end
                RUN: begin
                    // busy is raised on the first bit-slice edge so it spans
                    // exactly N cycles and drops together with the done pulse
                    busy    <= 1'b1;
                    work_a  <= work_a >> 1;
                    work_b  <= work_b >> 1;
                    shift_s <= {s_bit, shift_s[N-1:1]};
                    carry   <= c_next;
                    cnt     <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        carry_msb <= carry;
                        state     <= FIN;
                    end
                end
                FIN: begin
                    sum      <= shift_s;
                    cout     <= carry;
                    overflow <= carry_msb ^ carry;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    if (ACCUMULATE != 0) reg_a <= shift_s;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'h0: seg7 = 7'b1000000;
            4'h1: seg7 = 7'b1111001;
            4'h2: seg7 = 7'b0100100;
            4'h3: seg7 = 7'b0110000;
            4'h4: seg7 = 7'b0011001;
            4'h5: seg7 = 7'b0010010;
            4'h6: seg7 = 7'b0000010;
            4'h7: seg7 = 7'b1111000;
            4'h8: seg7 = 7'b0000000;
            4'h9: seg7 = 7'b0010000;
            4'hA: seg7 = 7'b0001000;
            4'hB: seg7 = 7'b0000011;
            4'hC: seg7 = 7'b1000110;
            4'hD: seg7 = 7'b0100001;
            4'hE: seg7 = 7'b0000110;
            default: seg7 = 7'b0001110;
        endcase
    endfunction

    assign sum_pad = PW'(sum);

    // Seven-segment decode of the result register, top nibble zero-padded
    always_comb begin
        hex_out = '1;
        for (int unsigned d = 0; d < NDIG; d++) begin
            hex_out[7*d +: 7] = seg7(sum_pad[4*d +: 4]);
        end
    end

endmodule

// File: tb/tb_addern_serial.sv
module tb_addern_serial;
    localparam int N = 8;

    typedef struct packed {
        logic [7:0] s;
        logic       c;
        logic       v;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  data_in = '0;
    logic        load_a = 1'b0, load_b = 1'b0, start = 1'b0, sub = 1'b0;
    logic        busy0, done0, cout0, ov0;
    logic        busy1, done1, cout1, ov1;
    logic [7:0]  sum0, sum1;
    logic [13:0] hex0, hex1;

    int checks = 0;
    int failures = 0;
    exp_t q0[$];
    exp_t q1[$];
    logic [7:0] ma, mb, macc;

    always #5 clk = ~clk;

    addern_serial #(.N(N), .ACCUMULATE(0)) dut (
        .CLOCK_50(clk), .Resetn(rst_n), .data_in(data_in),
        .load_a(load_a), .load_b(load_b), .start(start), .sub(sub),
        .busy(busy0), .done(done0), .sum(sum0), .cout(cout0),
        .overflow(ov0), .hex_out(hex0)
    );

    addern_serial #(.N(N), .ACCUMULATE(1)) dut_acc (
        .CLOCK_50(clk), .Resetn(rst_n), .data_in(data_in),
        .load_a(load_a), .load_b(load_b), .start(start), .sub(sub),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1),
        .overflow(ov1), .hex_out(hex1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [6:0] seg(input logic [3:0] v);
        logic [6:0] t [16];
        t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
              7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
              7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        return t[v];
    endfunction

    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic s);
        exp_t e;
        logic [7:0] bb;
        logic [8:0] r;
        bb  = s ? ~b : b;
        r   = {1'b0, a} + {1'b0, bb} + {8'd0, s};
        e.s = r[7:0];
        e.c = r[8];
        e.v = (a[7] == bb[7]) && (r[7] != a[7]);
        return e;
    endfunction

    // Scoreboard monitor for the plain instance
    always @(negedge clk) begin
        if (done0) begin
            if (q0.size() == 0) begin
                chk("dut_spurious_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q0.pop_front();
                chk("dut_sum", {24'd0, sum0}, {24'd0, e.s});
                chk("dut_cout", {31'd0, cout0}, {31'd0, e.c});
                chk("dut_ovf", {31'd0, ov0}, {31'd0, e.v});
                chk("dut_hex", {18'd0, hex0}, {18'd0, seg(e.s[7:4]), seg(e.s[3:0])});
            end
        end
    end

    // Scoreboard monitor for the accumulating instance
    always @(negedge clk) begin
        if (done1) begin
            if (q1.size() == 0) begin
                chk("acc_spurious_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q1.pop_front();
                chk("acc_sum", {24'd0, sum1}, {24'd0, e.s});
                chk("acc_cout", {31'd0, cout1}, {31'd0, e.c});
                chk("acc_ovf", {31'd0, ov1}, {31'd0, e.v});
            end
        end
    end

    task automatic do_load(input logic la, input logic lb, input logic [7:0] v);
        @(negedge clk);
        data_in = v;
        load_a  = la;
        load_b  = lb;
        @(negedge clk);
        load_a = 1'b0;
        load_b = 1'b0;
        if (la) begin ma = v; macc = v; end
        if (lb) mb = v;
    endtask

    // Issues a start; cycle c is the negedge following the c-th posedge from
    // the edge that sees the rise, so done after edge k+N+1 lands at c=N+2.
    task automatic do_start(input string nm, input logic sv, input bit reraise);
        logic s_eff;
        exp_t e;
        int done_at, busy_n, done_n;
`ifdef ADDERN_SUB_EN
        s_eff = sv;
`else
        s_eff = 1'b0;
`endif
        q0.push_back(model(ma, mb, s_eff));
        e = model(macc, mb, s_eff);
        q1.push_back(e);
        macc = e.s;
        @(negedge clk);
        start = 1'b1;
        sub   = sv;
        done_at = -1;
        busy_n  = 0;
        done_n  = 0;
        for (int c = 1; c <= N + 6; c++) begin
            @(negedge clk);
            if (c == 1) begin start = 1'b0; sub = 1'b0; end
            if (reraise && c == 3) start = 1'b1;
            if (reraise && c == 5) start = 1'b0;
            if (busy0) busy_n++;
            if (done0) begin
                done_n++;
                if (done_at < 0) done_at = c;
            end
        end
        chk({nm, "_done_latency"}, done_at, N + 2);
        chk({nm, "_busy_cycles"}, busy_n, N);
        chk({nm, "_done_count"}, done_n, 1);
    endtask

    initial begin
        logic seen_busy;
        ma = '0; mb = '0; macc = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_sum", {24'd0, sum0}, 32'd0);
        chk("rst_cout", {31'd0, cout0}, 32'd0);
        chk("rst_ovf", {31'd0, ov0}, 32'd0);
        chk("rst_busy", {31'd0, busy0}, 32'd0);
        chk("rst_done", {31'd0, done0}, 32'd0);
        chk("rst_hex", {18'd0, hex0}, {18'd0, 7'b1000000, 7'b1000000});
        @(negedge clk);
        rst_n = 1'b1;

        // 0x3C + 0x45 = 0x81, signed overflow, no carry
        do_load(1'b1, 1'b0, 8'h3C);
        do_load(1'b0, 1'b1, 8'h45);
        do_start("add3c45", 1'b0, 1'b0);
        chk("add3c45_sum", {24'd0, sum0}, 32'h81);
        chk("add3c45_hex", {18'd0, hex0}, {18'd0, 7'b0000000, 7'b1111001});

        // 0xFF + 0x01 wraps to 0x00 with carry out
        do_load(1'b1, 1'b0, 8'hFF);
        do_load(1'b0, 1'b1, 8'h01);
        do_start("addff01", 1'b0, 1'b0);
        chk("addff01_sum", {24'd0, sum0}, 32'h00);
        chk("addff01_cout", {31'd0, cout0}, 32'd1);

        // 0x10 - 0x20 in subtract mode, or 0x10 + 0x20 when it is compiled out
        do_load(1'b1, 1'b0, 8'h10);
        do_load(1'b0, 1'b1, 8'h20);
        do_start("sub1020", 1'b1, 1'b0);
`ifdef ADDERN_SUB_EN
        chk("sub1020_sum", {24'd0, sum0}, 32'hF0);
`else
        chk("sub1020_sum", {24'd0, sum0}, 32'h30);
`endif
        chk("sub1020_cout", {31'd0, cout0}, 32'd0);

        // Reset 4 cycles into a run aborts it with no done pulse
        do_load(1'b1, 1'b0, 8'h3C);
        do_load(1'b0, 1'b1, 8'h45);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy0}, 32'd0);
        chk("abort_done", {31'd0, done0}, 32'd0);
        chk("abort_sum", {24'd0, sum0}, 32'd0);
        chk("abort_hex", {18'd0, hex0}, {18'd0, 7'b1000000, 7'b1000000});
        ma = '0; mb = '0; macc = '0;
        @(negedge clk);
        rst_n = 1'b1;
        do_load(1'b1, 1'b0, 8'h3C);
        do_load(1'b0, 1'b1, 8'h45);
        do_start("after_abort", 1'b0, 1'b0);
        chk("after_abort_sum", {24'd0, sum0}, 32'h81);

        // load_a and start rising together: load taken, start dropped
        @(negedge clk);
        data_in = 8'h55;
        load_a  = 1'b1;
        start   = 1'b1;
        ma = 8'h55; macc = 8'h55;
        seen_busy = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            load_a = 1'b0;
            start  = 1'b0;
            if (busy0) seen_busy = 1'b1;
        end
        chk("ld_start_busy", {31'd0, seen_busy}, 32'd0);
        do_start("after_ld_start", 1'b0, 1'b0);
        chk("after_ld_start_sum", {24'd0, sum0}, 32'h9A);

        // start re-raised mid-run is ignored
        do_start("reraise", 1'b0, 1'b1);

        // Accumulate: 1 + 3 three times gives 4, 7, 10 on the accumulating copy
        do_load(1'b1, 1'b0, 8'h01);
        do_load(1'b0, 1'b1, 8'h03);
        do_start("acc1", 1'b0, 1'b0);
        do_start("acc2", 1'b0, 1'b0);
        do_start("acc3", 1'b0, 1'b0);
        chk("acc_final_sum", {24'd0, sum1}, 32'd10);
        chk("acc_final_hex", {18'd0, hex1}, {18'd0, 7'b1000000, 7'b0001000});
        chk("plain_final_sum", {24'd0, sum0}, 32'd4);

        repeat (2) @(negedge clk);
        chk("q_dut_empty", q0.size(), 32'd0);
        chk("q_acc_empty", q1.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
